// File: rtl/ecc_apb_sequencer_if.sv
// APB write-side bus between the ECC job sequencer (master) and the ECC block (slave).
interface ecc_apb_sequencer_if #(
    parameter int AMBA_WORD       = 32,
    parameter int AMBA_ADDR_WIDTH = 20
);
    logic [AMBA_ADDR_WIDTH-1:0] PADDR;
    logic                       PSEL;
    logic                       PENABLE;
    logic                       PWRITE;
    logic [AMBA_WORD-1:0]       PWDATA;

    modport master (output PADDR, PSEL, PENABLE, PWRITE, PWDATA);
    modport slave  (input  PADDR, PSEL, PENABLE, PWRITE, PWDATA);
endinterface

// File: rtl/ecc_apb_sequencer.sv
// Turns one job into four APB register writes, waits for the ECC block, returns the result.
// Optional WAIT-state timeout is enabled with `define ECC_SEQ_TIMEOUT_EN.
module ecc_apb_sequencer #(
    parameter int AMBA_WORD       = 32,
    parameter int AMBA_ADDR_WIDTH = 20,
    parameter int DATA_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  job_valid,
    output logic                  job_ready,
    input  logic [1:0]            job_ctrl,
    input  logic [1:0]            job_width,
    input  logic [AMBA_WORD-1:0]  job_data,
    input  logic [AMBA_WORD-1:0]  job_noise,
    ecc_apb_sequencer_if.master   apb,
    input  logic                  operation_done,
    input  logic [DATA_WIDTH-1:0] data_out,
    input  logic [1:0]            num_of_errors,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [DATA_WIDTH-1:0] res_data,
    output logic [1:0]            res_errors,
    output logic                  res_timeout
);

    localparam logic [AMBA_ADDR_WIDTH-1:0] ADDR_CTRL  = AMBA_ADDR_WIDTH'('h00);
    localparam logic [AMBA_ADDR_WIDTH-1:0] ADDR_DATA  = AMBA_ADDR_WIDTH'('h04);
    localparam logic [AMBA_ADDR_WIDTH-1:0] ADDR_WIDTH = AMBA_ADDR_WIDTH'('h08);
    localparam logic [AMBA_ADDR_WIDTH-1:0] ADDR_NOISE = AMBA_ADDR_WIDTH'('h0C);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_ACCESS = 3'd2,
        S_WAIT   = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    state_t                     state_q;
    logic [1:0]                 wr_idx_q;
    logic [1:0]                 ctrl_q;
    logic [1:0]                 width_q;
    logic [AMBA_WORD-1:0]       data_q;
    logic [AMBA_WORD-1:0]       noise_q;
    logic [AMBA_ADDR_WIDTH-1:0] paddr_q;
    logic [AMBA_WORD-1:0]       pwdata_q;
    logic                       psel_q;
    logic                       penable_q;
    logic                       pwrite_q;
    logic                       job_ready_q;
    logic                       res_valid_q;
    logic [DATA_WIDTH-1:0]      res_data_q;
    logic [1:0]                 res_errors_q;

    logic [1:0]                 wr_idx_d;
    logic [AMBA_ADDR_WIDTH-1:0] wr_addr_d;
    logic [AMBA_WORD-1:0]       wr_data_d;

`ifdef ECC_SEQ_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] tmo_cnt_q;
    logic             res_timeout_q;
`endif

    // Address/data of the write that follows the current one; write 0 is loaded at acceptance.
    always_comb begin
        wr_idx_d  = wr_idx_q + 2'd1;
        wr_addr_d = ADDR_DATA;
        wr_data_d = data_q;
        case (wr_idx_d)
            2'd1: begin
                wr_addr_d = ADDR_WIDTH;
                wr_data_d = AMBA_WORD'(width_q);
            end
            2'd2: begin
                wr_addr_d = ADDR_NOISE;
                wr_data_d = noise_q;
            end
            2'd3: begin
                wr_addr_d = ADDR_CTRL;
                wr_data_d = AMBA_WORD'(ctrl_q);
            end
            default: begin
                wr_addr_d = ADDR_DATA;
                wr_data_d = data_q;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            wr_idx_q     <= '0;
            ctrl_q       <= '0;
            width_q      <= '0;
            data_q       <= '0;
            noise_q      <= '0;
            paddr_q      <= '0;
            pwdata_q     <= '0;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            pwrite_q     <= 1'b0;
            job_ready_q  <= 1'b0;
            res_valid_q  <= 1'b0;
            res_data_q   <= '0;
            res_errors_q <= '0;
`ifdef ECC_SEQ_TIMEOUT_EN
            tmo_cnt_q     <= '0;
            res_timeout_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    // job_ready is still low only on the first cycle after reset release.
                    if (!job_ready_q) begin
                        job_ready_q <= 1'b1;
                    end else if (job_valid) begin
                        ctrl_q      <= job_ctrl;
                        width_q     <= job_width;
                        data_q      <= job_data;
                        noise_q     <= job_noise;
                        job_ready_q <= 1'b0;
                        wr_idx_q    <= 2'd0;
                        paddr_q     <= ADDR_DATA;
                        pwdata_q    <= job_data;
                        psel_q      <= 1'b1;
                        pwrite_q    <= 1'b1;
                        penable_q   <= 1'b0;
                        state_q     <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (wr_idx_q == 2'd3) begin
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        pwrite_q  <= 1'b0;
                        paddr_q   <= '0;
                        pwdata_q  <= '0;
                        state_q   <= S_WAIT;
`ifdef ECC_SEQ_TIMEOUT_EN
                        tmo_cnt_q <= '0;
`endif
                    end else begin
                        wr_idx_q  <= wr_idx_d;
                        paddr_q   <= wr_addr_d;
                        pwdata_q  <= wr_data_d;
                        penable_q <= 1'b0;
                        state_q   <= S_SETUP;
                    end
                end
                S_WAIT: begin
                    if (operation_done) begin
                        res_data_q   <= data_out;
                        res_errors_q <= num_of_errors;
                        res_valid_q  <= 1'b1;
                        state_q      <= S_RESP;
`ifdef ECC_SEQ_TIMEOUT_EN
                        res_timeout_q <= 1'b0;
                    end else if (tmo_cnt_q == CNT_LAST) begin
                        res_data_q    <= '0;
                        res_errors_q  <= '0;
                        res_timeout_q <= 1'b1;
                        res_valid_q   <= 1'b1;
                        state_q       <= S_RESP;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
`endif
                    end
                end
                S_RESP: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        job_ready_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign job_ready   = job_ready_q;
    assign res_valid   = res_valid_q;
    assign res_data    = res_data_q;
    assign res_errors  = res_errors_q;
    assign apb.PADDR   = paddr_q;
    assign apb.PSEL    = psel_q;
    assign apb.PENABLE = penable_q;
    assign apb.PWRITE  = pwrite_q;
    assign apb.PWDATA  = pwdata_q;

`ifdef ECC_SEQ_TIMEOUT_EN
    assign res_timeout = res_timeout_q;
`else
    wire unused_tmo_cfg = (TIMEOUT_CYCLES != 0);
    assign res_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_ecc_apb_sequencer.sv
// Directed bench: stimulus pushes expected APB writes/results; a negedge monitor pops and compares.
module tb_ecc_apb_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        job_valid = 1'b0;
    logic        job_ready;
    logic [1:0]  job_ctrl = '0;
    logic [1:0]  job_width = '0;
    logic [31:0] job_data = '0;
    logic [31:0] job_noise = '0;
    logic        operation_done = 1'b0;
    logic [31:0] data_out = '0;
    logic [1:0]  num_of_errors = '0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [31:0] res_data;
    logic [1:0]  res_errors;
    logic        res_timeout;

    ecc_apb_sequencer_if #(.AMBA_WORD(32), .AMBA_ADDR_WIDTH(20)) apb_if ();

    ecc_apb_sequencer #(
        .AMBA_WORD(32), .AMBA_ADDR_WIDTH(20), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rst(rst),
        .job_valid(job_valid), .job_ready(job_ready),
        .job_ctrl(job_ctrl), .job_width(job_width),
        .job_data(job_data), .job_noise(job_noise),
        .apb(apb_if),
        .operation_done(operation_done), .data_out(data_out), .num_of_errors(num_of_errors),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_errors(res_errors), .res_timeout(res_timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [19:0] addr; logic [31:0] data; int cyc; } wr_t;
    typedef struct { logic [31:0] data; logic [1:0] err; logic to; int cyc; } res_t;
    wr_t  exp_wr[$];
    res_t exp_res[$];

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: APB writes on ACCESS cycles, results on the valid/ready handshake.
    logic        prev_psel = 1'b0, prev_pen = 1'b0, prev_pwrite = 1'b0, rv_prev = 1'b0;
    logic [19:0] prev_addr = '0;
    logic [31:0] prev_data = '0;
    int          rise_cyc = 0;
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (apb_if.PSEL && apb_if.PENABLE) begin
                if (exp_wr.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious_write addr=%0h data=%0h required=none", apb_if.PADDR, apb_if.PWDATA);
                end else begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    $display("apb write addr=%0h data=%0h cycle=%0d", apb_if.PADDR, apb_if.PWDATA, cyc);
                    check("wr_addr", 64'(apb_if.PADDR), 64'(e.addr));
                    check("wr_data", 64'(apb_if.PWDATA), 64'(e.data));
                    check("wr_cycle", 64'(cyc), 64'(e.cyc));
                    check("setup_phase", {prev_psel, prev_pen, prev_pwrite, apb_if.PWRITE, prev_addr, prev_data},
                          {1'b1, 1'b0, 1'b1, 1'b1, apb_if.PADDR, apb_if.PWDATA});
                end
            end else if (!apb_if.PSEL) begin
                check("idle_bus", {apb_if.PENABLE, apb_if.PWRITE, apb_if.PADDR, apb_if.PWDATA}, 64'd0);
            end
            if (res_valid && !rv_prev) rise_cyc = cyc;
            if (res_valid && res_ready) begin
                if (exp_res.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious_result data=%0h required=none", res_data);
                end else begin
                    res_t r;
                    r = exp_res.pop_front();
                    $display("result data=%0h errors=%0d timeout=%0b cycle=%0d", res_data, res_errors, res_timeout, cyc);
                    check("res_data", 64'(res_data), 64'(r.data));
                    check("res_errors", 64'(res_errors), 64'(r.err));
                    check("res_timeout", 64'(res_timeout), 64'(r.to));
                    check("res_rise_cycle", 64'(rise_cyc), 64'(r.cyc));
                end
            end
        end
        prev_psel   = apb_if.PSEL;
        prev_pen    = apb_if.PENABLE;
        prev_pwrite = apb_if.PWRITE;
        prev_addr   = apb_if.PADDR;
        prev_data   = apb_if.PWDATA;
        rv_prev     = (rst === 1'b1) ? res_valid : 1'b0;
    end

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic submit(input logic [1:0] c, input logic [1:0] w, input logic [31:0] d,
                          input logic [31:0] n, output int a);
        int guard = 0;
        while (!job_ready && guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("job_ready_before_submit", 64'(job_ready), 64'd1);
        job_valid = 1'b1;
        job_ctrl  = c;
        job_width = w;
        job_data  = d;
        job_noise = n;
        @(posedge clk);
        #1;
        job_valid = 1'b0;
        job_data  = 32'hFFFF_FFFF;
        job_noise = 32'hFFFF_FFFF;
        job_ctrl  = 2'b11;
        job_width = 2'b11;
        a = cyc;
        exp_wr.push_back('{20'h04, d, a + 1});
        exp_wr.push_back('{20'h08, {30'd0, w}, a + 3});
        exp_wr.push_back('{20'h0C, n, a + 5});
        exp_wr.push_back('{20'h00, {30'd0, c}, a + 7});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        rst = 1'b1;
        #1 rst = 1'b0;
        #2;
        check("reset_outputs", {job_ready, res_valid, res_timeout, res_errors, apb_if.PSEL, apb_if.PENABLE, apb_if.PWRITE},
              64'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        check("job_ready_before_first_edge", 64'(job_ready), 64'd0);
        @(posedge clk);
        #1;
        check("job_ready_after_release", 64'(job_ready), 64'd1);

        // Job 1: basic write sequence, capture, 10-cycle back-pressure.
        submit(2'd1, 2'd2, 32'h0000_00A5, 32'h0, a);
        check("job_ready_low_after_accept", 64'(job_ready), 64'd0);
        exp_res.push_back('{32'h1234_5678, 2'd1, 1'b0, a + 13});
        goto(a + 12);
        check("no_result_before_done", 64'(res_valid), 64'd0);
        operation_done = 1'b1;
        data_out       = 32'h1234_5678;
        num_of_errors  = 2'd1;
        goto(a + 13);
        operation_done = 1'b0;
        data_out       = 32'hFFFF_FFFF;
        num_of_errors  = 2'd3;
        for (int i = 0; i < 10; i++) begin
            check("hold_valid_ready", {res_valid, job_ready, res_errors, res_data}, {1'b1, 1'b0, 2'd1, 32'h1234_5678});
            @(posedge clk);
            #1;
        end
        res_ready = 1'b1;
        @(posedge clk);
        #1 res_ready = 1'b0;
        check("after_handshake", {res_valid, job_ready, res_data}, {1'b0, 1'b1, 32'h1234_5678});

        // Job 2: done pulse during the NOISE write must be ignored.
        submit(2'd3, 2'd1, 32'h0000_0F0F, 32'h8000_0001, a);
        goto(a + 4);
        operation_done = 1'b1;
        data_out       = 32'hBAD0_BAD0;
        num_of_errors  = 2'd2;
        goto(a + 6);
        operation_done = 1'b0;
        goto(a + 12);
        check("early_done_ignored", 64'(res_valid), 64'd0);
        res_ready = 1'b1;
        exp_res.push_back('{32'hCAFE_F00D, 2'd3, 1'b0, a + 14});
        goto(a + 13);
        operation_done = 1'b1;
        data_out       = 32'hCAFE_F00D;
        num_of_errors  = 2'd3;
        goto(a + 14);
        operation_done = 1'b0;
        data_out       = 32'h7777_7777;
        check("valid_after_late_done", 64'(res_valid), 64'd1);
        goto(a + 15);
        check("valid_cleared", 64'(res_valid), 64'd0);
        res_ready = 1'b0;

        // Job 3: timeout when enabled, indefinite WAIT otherwise.
        submit(2'd0, 2'd3, 32'h5555_AAAA, 32'h0000_0100, a);
`ifdef ECC_SEQ_TIMEOUT_EN
        exp_res.push_back('{32'h0, 2'd0, 1'b1, a + 24});
        res_ready = 1'b1;
        goto(a + 23);
        check("no_timeout_yet", 64'(res_valid), 64'd0);
        goto(a + 24);
        check("timeout_result", {res_valid, res_timeout, res_data}, {1'b1, 1'b1, 32'h0});
        goto(a + 25);
        res_ready = 1'b0;
`else
        goto(a + 48);
        check("wait_indefinite", {res_valid, res_timeout, job_ready}, 64'd0);
        exp_res.push_back('{32'h0000_FFFF, 2'd0, 1'b0, a + 49});
        operation_done = 1'b1;
        data_out       = 32'h0000_FFFF;
        num_of_errors  = 2'd0;
        res_ready      = 1'b1;
        goto(a + 49);
        operation_done = 1'b0;
        goto(a + 50);
        res_ready = 1'b0;
`endif

        // Job 4: reset asserted during the CODEWORD_WIDTH ACCESS cycle.
        submit(2'd2, 2'd3, 32'hDEAD_BEEF, 32'h0000_0011, a);
        goto(a + 3);
        #1 rst = 1'b0;
        #1;
        check("async_reset_bus", {apb_if.PSEL, apb_if.PENABLE, apb_if.PWRITE, apb_if.PADDR, apb_if.PWDATA}, 64'd0);
        check("async_reset_res", {job_ready, res_valid, res_errors, res_data}, 64'd0);
        exp_wr.delete();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        check("job_ready_after_mid_reset", 64'(job_ready), 64'd1);
        repeat (20) @(posedge clk);
        #1;
        check("wr_queue_empty", 64'(exp_wr.size()), 64'd0);
        check("res_queue_empty", 64'(exp_res.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ecc_apb_sequencer.md
ECC_APB_SEQUENCER -- requirements
Module: ecc_apb_sequencer

Interface
REQ-001 Parameter AMBA_WORD, default 32, APB data width.
REQ-002 Parameter AMBA_ADDR_WIDTH, default 20, APB address width.
REQ-003 Parameter DATA_WIDTH, default 32, ECC result data width.
REQ-004 Parameter TIMEOUT_CYCLES, default 1024, WAIT-state cycle limit (used only with ECC_SEQ_TIMEOUT_EN).
REQ-005 Port clk  input  1  single clock, all state on its rising edge.
REQ-006 Port rst  input  1  reset, asynchronous, active-low.
REQ-007 Port job_valid  input  1  job request.
REQ-008 Port job_ready  output  1  sequencer can accept a job.
REQ-009 Port job_ctrl  input  2  value for the ECC CTRL register (operation select).
REQ-010 Port job_width  input  2  value for the CODEWORD_WIDTH register.
REQ-011 Port job_data  input  AMBA_WORD  value for the DATA_IN register.
REQ-012 Port job_noise  input  AMBA_WORD  value for the NOISE register.
REQ-013 Port PADDR  output  AMBA_ADDR_WIDTH  APB address to the ECC block.
REQ-014 Port PSEL  output  1  APB select.
REQ-015 Port PENABLE  output  1  APB enable.
REQ-016 Port PWRITE  output  1  APB write strobe.
REQ-017 Port PWDATA  output  AMBA_WORD  APB write data.
REQ-018 Port operation_done  input  1  ECC block completion pulse.
REQ-019 Port data_out  input  DATA_WIDTH  ECC block result data.
REQ-020 Port num_of_errors  input  2  ECC block error count.
REQ-021 Port res_valid  output  1  result available.
REQ-022 Port res_ready  input  1  consumer accepts the result.
REQ-023 Port res_data  output  DATA_WIDTH  captured data_out.
REQ-024 Port res_errors  output  2  captured num_of_errors.
REQ-025 Port res_timeout  output  1  job ended by timeout, not by operation_done.

Function
REQ-026 FSM states SHALL be IDLE, SETUP, ACCESS, WAIT and RESP; job_ready SHALL be 1 only in IDLE.
REQ-027 A job SHALL be accepted on the rising edge where job_valid=1 and job_ready=1; all job fields are latched on that edge.
REQ-028 After acceptance, four APB writes SHALL run in fixed order: DATA_IN 0x04, CODEWORD_WIDTH 0x08, NOISE 0x0C, CTRL 0x00 (the CTRL write starts the ECC block).
REQ-029 Each write SHALL be 1 SETUP cycle (PSEL=1, PENABLE=0, PWRITE=1) then 1 ACCESS cycle (PSEL=1, PENABLE=1); PADDR and PWDATA are stable across both cycles. No wait states are inserted; the write phase is exactly 8 cycles.
REQ-030 Outside SETUP/ACCESS: PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0.
REQ-031 Only the two low bits of CTRL and CODEWORD_WIDTH SHALL be driven; all other PWDATA bits are zero.
REQ-032 WAIT SHALL follow the last ACCESS; operation_done SHALL be sampled only in WAIT, and pulses during the write phase are ignored.
REQ-033 operation_done=1 in WAIT SHALL capture data_out and num_of_errors into res_data and res_errors, and move to RESP on the next cycle.
REQ-034 RESP SHALL hold res_valid=1 with stable res_data, res_errors and res_timeout until res_valid and res_ready are both 1, then return to IDLE.
REQ-035 A new job SHALL be accepted no earlier than the cycle after the RESP handshake; there is no back-to-back overlap.
REQ-036 res_data, res_errors and res_timeout SHALL keep their last values after the handshake until the next capture.

Reset
REQ-037 rst=0 SHALL immediately force IDLE, with every output at 0 (job_ready becomes 1 on the first edge after release), including mid-write or mid-WAIT; the aborted job is discarded.
REQ-038 The timeout counter and all latched job fields SHALL be cleared by reset.

Configuration
REQ-039 With ECC_SEQ_TIMEOUT_EN defined: a counter SHALL clear on entry to WAIT and increment each WAIT cycle. On reaching TIMEOUT_CYCLES without operation_done, it SHALL enter RESP with res_timeout=1, res_data=0, res_errors=0. If operation_done and expiry coincide, operation_done wins.
REQ-040 Without ECC_SEQ_TIMEOUT_EN: no counter exists, WAIT lasts indefinitely, and res_timeout is tied to 0.

Verification
REQ-041 Job ctrl=1, width=2, data=0x0000_00A5, noise=0 -> APB writes 0x04/0xA5, 0x08/0x2, 0x0C/0x0, 0x00/0x1 on cycles 1-8; WAIT from cycle 9.
REQ-042 operation_done 5 cycles into WAIT with data_out=0x1234_5678 and num_of_errors=1 -> res_valid=1 next cycle with res_data=0x1234_5678, res_errors=1, res_timeout=0.
REQ-043 res_ready held 0 for 10 cycles -> res_valid and res_data stable for all 10; job_ready=0 throughout.
REQ-044 operation_done pulsed during the NOISE write -> ignored; sequencer still waits for a pulse in WAIT.
REQ-045 rst=0 during the CODEWORD_WIDTH ACCESS cycle -> PSEL and PENABLE drop asynchronously; after release, job_ready=1 and no further writes occur.
REQ-046 ECC_SEQ_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, no operation_done -> RESP after 16 WAIT cycles with res_timeout=1, res_data=0.
